lsu_rmw: RTL

- Load/store unit between the core's memory stage and dmem.
- Accepts one byte, halfword or word load/store per handshake and drives word-aligned accesses to dmem.
- Performs sub-word stores as a two-step read-modify-write, because dmem writes whole words.
- Sign/zero-extends load data and flags misaligned or out-of-range accesses.

---
 rtl/lsu_rmw.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lsu_rmw.sv
// Load/store unit between the memory stage and a word-wide dmem.
// Sub-word stores are done as read-modify-write over two cycles.
module lsu_rmw #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_we,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      state, state_nx;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] merged_q, rdata_q;
    logic [3:0]  mask_q;

    logic        illegal, misaligned, out_of_range, err;
    logic        sub_store, word_store;
    logic [4:0]  shamt;
    logic [31:0] rd_sh, load_ext, lane32, merged;
    logic [3:0]  sub_mask;

    // Error decode runs off the registered request, so it is stable from ACCESS through RESP.
    assign illegal      = (r_f3 == 3'b011) || (r_f3[2:1] == 2'b11) || (r_f3[2] && r_we);
    assign misaligned   = ((r_f3[1:0] == 2'b01) && r_addr[0]) ||
                          ((r_f3 == 3'b010) && (r_addr[1:0] != 2'b00));
    assign out_of_range = r_addr[31:2] >= 30'(MEM_WORDS);
    assign err          = illegal || misaligned || out_of_range;

    assign sub_store  = r_we && ((r_f3 == 3'b000) || (r_f3 == 3'b001));
    assign word_store = r_we && (r_f3 == 3'b010);

    assign shamt    = {r_addr[1:0], 3'b000};
    assign rd_sh    = mem_rd >> shamt;
    assign sub_mask = ((r_f3 == 3'b000) ? 4'b0001 : 4'b0011) << r_addr[1:0];
    assign lane32   = {{8{sub_mask[3]}}, {8{sub_mask[2]}}, {8{sub_mask[1]}}, {8{sub_mask[0]}}};
    assign merged   = (mem_rd & ~lane32) | ((r_wdata << shamt) & lane32);

    always_comb begin
        load_ext = '0;
        case (r_f3)
            3'b000:  load_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b001:  load_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b010:  load_ext = mem_rd;
            3'b100:  load_ext = {24'h0, rd_sh[7:0]};
            3'b101:  load_ext = {16'h0, rd_sh[15:0]};
            default: load_ext = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            r_we     <= 1'b0;
            r_f3     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            mask_q   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (state == ACCESS) begin
                rdata_q  <= (!r_we && !err) ? load_ext : '0;
                merged_q <= merged;
                mask_q   <= sub_mask;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        mem_wmask = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = ACCESS;
            end
            ACCESS: begin
                mem_a    = {r_addr[31:2], 2'b00};
                state_nx = RESP;
                if (!err && word_store) begin
                    mem_we    = 1'b1;
                    mem_wd    = r_wdata;
                    mem_wmask = 4'b1111;
                end else if (!err && sub_store) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                mem_a     = {r_addr[31:2], 2'b00};
                mem_we    = 1'b1;
                mem_wd    = merged_q;
                mem_wmask = mask_q;
                state_nx  = RESP;
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Reset kills an in-flight write before the async state clear settles.
        if (reset) mem_we = 1'b0;
    end

    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err;
    assign resp_rdata = (state == RESP) ? rdata_q : '0;

endmodule
